// File: rtl/fft_mult_sched_if.sv
// Handshake and address bus of the 64-point FFT butterfly scheduler.
//   start, stall                 : controller -> scheduler
//   busy, done, stage            : scheduler status
//   rd_en, rd_addr_a/b, tw_addr  : butterfly issue (operand read + twiddle index)
//   wr_en, wr_addr_a/b           : delayed result write-back
interface fft_mult_sched_if;
    logic       start;
    logic       stall;
    logic       busy;
    logic       done;
    logic [2:0] stage;
    logic       rd_en;
    logic [5:0] rd_addr_a;
    logic [5:0] rd_addr_b;
    logic [4:0] tw_addr;
    logic       wr_en;
    logic [5:0] wr_addr_a;
    logic [5:0] wr_addr_b;

    // Scheduler side
    modport slave (
        input  start, stall,
        output busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               wr_en, wr_addr_a, wr_addr_b
    );

    // Controller / memory side
    modport master (
        output start, stall,
        input  busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               wr_en, wr_addr_a, wr_addr_b
    );
endinterface

// File: rtl/fft_mult_sched.sv
// Radix-2 64-point FFT butterfly scheduler: walks 6 stages x 32 butterflies,
// issues operand/twiddle addresses, and replays them PIPE_LAT cycles later as
// write-back strobes. Each stage drains the pipeline before the next starts.
// Ports:
//   clk      : clock
//   reset_n  : asynchronous active-low reset
//   bus      : fft_mult_sched_if.slave (start/stall in; status, read, write out)
module fft_mult_sched #(
    parameter int unsigned PIPE_LAT = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    fft_mult_sched_if.slave   bus
);
    localparam int unsigned AW     = 6;
    localparam int unsigned TW     = 5;
    localparam int unsigned KW     = 5;
    localparam int unsigned SW     = 3;
    localparam int unsigned CW     = 4;
    localparam int unsigned NSTAGE = 6;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t         r_state;
    logic [SW-1:0]  r_stage;
    logic [KW-1:0]  r_k;
    logic [CW-1:0]  r_drain;
    logic           r_busy;
    logic           r_done;
    logic [AW-1:0]  r_rd_a;
    logic [AW-1:0]  r_rd_b;
    logic [TW-1:0]  r_tw;

    logic [PIPE_LAT-1:0] r_pv;
    logic [AW-1:0]       r_pa [PIPE_LAT];
    logic [AW-1:0]       r_pb [PIPE_LAT];

    logic           w_fire;
    logic           w_ld;
    logic [SW-1:0]  w_ld_stage;
    logic [KW-1:0]  w_ld_k;
    logic [KW-1:0]  w_mask;
    logic [KW-1:0]  w_pos;
    logic [AW-1:0]  w_span;
    logic [AW-1:0]  w_a;
    logic [AW-1:0]  w_b;
    logic [TW-1:0]  w_tw;

    // Stall gates the issue in the same cycle, so the strobe is not registered.
    assign w_fire = (r_state == ISSUE) && !bus.stall;

    // Next butterfly (stage, k) whose addresses must be presented next cycle.
    always_comb begin
        w_ld       = 1'b0;
        w_ld_stage = r_stage;
        w_ld_k     = r_k;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_ld       = 1'b1;
                    w_ld_stage = '0;
                    w_ld_k     = '0;
                end
            end
            ISSUE: begin
                if (w_fire && (r_k != KW'(31))) begin
                    w_ld   = 1'b1;
                    w_ld_k = r_k + KW'(1);
                end
            end
            DRAIN: begin
                if ((r_drain == CW'(1)) && (r_stage != SW'(NSTAGE - 1))) begin
                    w_ld       = 1'b1;
                    w_ld_stage = r_stage + SW'(1);
                    w_ld_k     = '0;
                end
            end
            default: ;
        endcase
    end

    // Address generation: group stride is 2*span, twiddle step is 32/span.
    always_comb begin
        w_mask = KW'((AW'(1) << w_ld_stage) - AW'(1));
        w_pos  = w_ld_k & w_mask;
        w_span = AW'(1) << w_ld_stage;
        w_a    = ((AW'(w_ld_k) >> w_ld_stage) << (w_ld_stage + SW'(1))) | AW'(w_pos);
        w_b    = w_a + w_span;
        w_tw   = TW'(w_pos << (SW'(5) - w_ld_stage));
    end

    // Control FSM with registered status and read addresses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_stage <= '0;
            r_k     <= '0;
            r_drain <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rd_a  <= '0;
            r_rd_b  <= '0;
            r_tw    <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_ld) begin
                r_stage <= w_ld_stage;
                r_k     <= w_ld_k;
                r_rd_a  <= w_a;
                r_rd_b  <= w_b;
                r_tw    <= w_tw;
            end
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state <= ISSUE;
                        r_busy  <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (w_fire && (r_k == KW'(31))) begin
                        r_state <= DRAIN;
                        r_drain <= CW'(PIPE_LAT);
                    end
                end
                DRAIN: begin
                    if (r_drain == CW'(1)) begin
                        r_drain <= '0;
                        if (r_stage == SW'(NSTAGE - 1)) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ISSUE;
                        end
                    end else begin
                        r_drain <= r_drain - CW'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Write-back delay line; keeps shifting through stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pv <= '0;
            for (int i = 0; i < int'(PIPE_LAT); i++) begin
                r_pa[i] <= '0;
                r_pb[i] <= '0;
            end
        end else begin
            r_pv[0] <= w_fire;
            r_pa[0] <= r_rd_a;
            r_pb[0] <= r_rd_b;
            for (int i = 1; i < int'(PIPE_LAT); i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pa[i] <= r_pa[i-1];
                r_pb[i] <= r_pb[i-1];
            end
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.stage     = r_stage;
    assign bus.rd_en     = w_fire;
    assign bus.rd_addr_a = r_rd_a;
    assign bus.rd_addr_b = r_rd_b;
    assign bus.tw_addr   = r_tw;
    assign bus.wr_en     = r_pv[PIPE_LAT-1];
    assign bus.wr_addr_a = r_pa[PIPE_LAT-1];
    assign bus.wr_addr_b = r_pb[PIPE_LAT-1];
endmodule

// File: tb/tb_fft_mult_sched.sv
// Scoreboard bench: three schedulers (PIPE_LAT 1, 3, 8) driven side by side.
module tb_fft_mult_sched;
    localparam int NI  = 3;
    localparam int NBF = 192;

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 3 : 8);
    endfunction

    typedef struct {
        int due;
        int a;
        int b;
    } wr_exp_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NI-1:0] tb_start = '0;
    logic [NI-1:0] tb_stall = '0;
    int            cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       w_busy  [NI];
    logic       w_done  [NI];
    logic [2:0] w_stage [NI];
    logic       w_rd_en [NI];
    logic [5:0] w_rd_a  [NI];
    logic [5:0] w_rd_b  [NI];
    logic [4:0] w_tw    [NI];
    logic       w_wr_en [NI];
    logic [5:0] w_wr_a  [NI];
    logic [5:0] w_wr_b  [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        fft_mult_sched_if bus ();
        fft_mult_sched #(.PIPE_LAT(lat_of(g))) dut (
            .clk     (clk),
            .reset_n (reset_n),
            .bus     (bus)
        );
        assign bus.start  = tb_start[g];
        assign bus.stall  = tb_stall[g];
        assign w_busy[g]  = bus.busy;
        assign w_done[g]  = bus.done;
        assign w_stage[g] = bus.stage;
        assign w_rd_en[g] = bus.rd_en;
        assign w_rd_a[g]  = bus.rd_addr_a;
        assign w_rd_b[g]  = bus.rd_addr_b;
        assign w_tw[g]    = bus.tw_addr;
        assign w_wr_en[g] = bus.wr_en;
        assign w_wr_a[g]  = bus.wr_addr_a;
        assign w_wr_b[g]  = bus.wr_addr_b;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s inst=%0d cyc=%0d: got %0d expected %0d", nm, inst, cyc, act, exp);
        end
    endtask

    // Butterfly n (0..191) -> stage and addresses straight from the FFT index rules.
    function automatic void ref_addr(input int n, output int s, output int a,
                                     output int b, output int tw);
        int k, span, grp, pos;
        s    = n / 32;
        k    = n % 32;
        span = 2 ** s;
        grp  = k / span;
        pos  = k % span;
        a    = (grp * 2 * span + pos) % 64;
        b    = (a + span) % 64;
        tw   = (pos * (32 / span)) % 32;
    endfunction

    // Reference model state, owned by the monitor.
    bit      m_active  [NI];
    int      m_n       [NI];
    int      m_next    [NI];
    int      m_done_c  [NI];
    int      m_start_c [NI];
    int      m_stalls  [NI];
    int      rd_cnt    [NI];
    int      wr_cnt    [NI];
    int      dut_done_c[NI];
    wr_exp_t sb        [NI][$];

    // Stimulus -> monitor end-of-transform check request.
    int chk_req = 0;
    int chk_ack = 0;
    int exp_done_rel [NI];

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            bit was_active, in_issue, exp_rd, exp_wr;
            int s, a, b, tw;
            if (!reset_n) begin
                chk("busy_rst",  i, 32'(w_busy[i]),  0);
                chk("done_rst",  i, 32'(w_done[i]),  0);
                chk("stage_rst", i, 32'(w_stage[i]), 0);
                chk("rd_en_rst", i, 32'(w_rd_en[i]), 0);
                chk("rd_a_rst",  i, 32'(w_rd_a[i]),  0);
                chk("rd_b_rst",  i, 32'(w_rd_b[i]),  0);
                chk("tw_rst",    i, 32'(w_tw[i]),    0);
                chk("wr_en_rst", i, 32'(w_wr_en[i]), 0);
                chk("wr_a_rst",  i, 32'(w_wr_a[i]),  0);
                chk("wr_b_rst",  i, 32'(w_wr_b[i]),  0);
                m_active[i] = 1'b0;
                sb[i].delete();
            end else begin
                was_active = m_active[i];
                in_issue   = m_active[i] && (cyc >= m_next[i]) && (m_n[i] < NBF);
                exp_rd     = in_issue && !tb_stall[i];
                if (in_issue && tb_stall[i]) m_stalls[i]++;
                chk("rd_en", i, 32'(w_rd_en[i]), 32'(exp_rd));
                if (w_rd_en[i] === 1'b1) rd_cnt[i]++;
                if (exp_rd) begin
                    ref_addr(m_n[i], s, a, b, tw);
                    chk("stage", i, 32'(w_stage[i]), s);
                    chk("rd_a",  i, 32'(w_rd_a[i]),  a);
                    chk("rd_b",  i, 32'(w_rd_b[i]),  b);
                    chk("tw",    i, 32'(w_tw[i]),    tw);
                    sb[i].push_back('{cyc + lat_of(i), a, b});
                    m_n[i]++;
                    if (m_n[i] % 32 == 0) begin
                        m_next[i] = cyc + lat_of(i) + 1;
                        if (m_n[i] == NBF) m_done_c[i] = cyc + lat_of(i) + 1;
                    end
                end
                exp_wr = (sb[i].size() > 0) && (sb[i][0].due == cyc);
                chk("wr_en", i, 32'(w_wr_en[i]), 32'(exp_wr));
                if (exp_wr) begin
                    chk("wr_a", i, 32'(w_wr_a[i]), sb[i][0].a);
                    chk("wr_b", i, 32'(w_wr_b[i]), sb[i][0].b);
                    void'(sb[i].pop_front());
                end
                if (w_wr_en[i] === 1'b1) wr_cnt[i]++;
                chk("done", i, 32'(w_done[i]), 32'(m_active[i] && (cyc == m_done_c[i])));
                if ((w_done[i] === 1'b1) && (dut_done_c[i] < 0)) dut_done_c[i] = cyc;
                chk("busy", i, 32'(w_busy[i]), 32'(m_active[i]));
                if (m_active[i] && (cyc == m_done_c[i])) m_active[i] = 1'b0;
                if (!was_active && tb_start[i]) begin
                    m_active[i]   = 1'b1;
                    m_n[i]        = 0;
                    m_next[i]     = cyc + 1;
                    m_done_c[i]   = -1;
                    m_start_c[i]  = cyc;
                    m_stalls[i]   = 0;
                    rd_cnt[i]     = 0;
                    wr_cnt[i]     = 0;
                    dut_done_c[i] = -1;
                end
            end
        end
        if (chk_req != chk_ack) begin
            for (int i = 0; i < NI; i++) begin
                int exp_rel;
                exp_rel = (exp_done_rel[i] >= 0) ? exp_done_rel[i]
                        : 6 * (32 + lat_of(i)) + 1 + m_stalls[i];
                chk("rd_count",   i, rd_cnt[i], NBF);
                chk("wr_count",   i, wr_cnt[i], NBF);
                chk("done_cycle", i, dut_done_c[i] - m_start_c[i], exp_rel);
                chk("sb_empty",   i, sb[i].size(), 0);
            end
            chk_ack = chk_req;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic request_checks();
        chk_req++;
        for (int w = 0; (w < 10) && (chk_ack != chk_req); w++) next_cycle();
    endtask

    initial begin
        repeat (3) next_cycle();
        reset_n = 1'b1;
        repeat (2) next_cycle();

        // Transform 1: deterministic stall at stage 2 k=7 on the PIPE_LAT=3 unit,
        // extra starts while busy and in each unit's DONE cycle.
        tb_start = '1;
        next_cycle();
        for (int t = 1; t <= 260; t++) begin
            tb_start    = '0;
            tb_stall    = '0;
            tb_stall[1] = (t >= 78) && (t <= 81);
            if (t == 50)  tb_start    = '1;
            if (t == 199) tb_start[0] = 1'b1;
            if (t == 215) tb_start[1] = 1'b1;
            if (t == 241) tb_start[2] = 1'b1;
            next_cycle();
        end
        tb_start = '0;
        tb_stall = '0;
        exp_done_rel[0] = 199;
        exp_done_rel[1] = 215;
        exp_done_rel[2] = 241;
        request_checks();

        // Transform 2: random stalls everywhere, random ignored starts while busy.
        for (int i = 0; i < NI; i++) exp_done_rel[i] = -1;
        tb_start = '1;
        next_cycle();
        for (int t = 1; t <= 480; t++) begin
            for (int i = 0; i < NI; i++) begin
                tb_stall[i] = (t < 400) && ($urandom_range(0, 3) == 0);
                tb_start[i] = (t < 150) && ($urandom_range(0, 19) == 0);
            end
            next_cycle();
        end
        tb_start = '0;
        tb_stall = '0;
        request_checks();

        // Transform 3: reset mid-run at cycle 100, then no activity without a start.
        tb_start = '1;
        next_cycle();
        tb_start = '0;
        for (int t = 1; t < 100; t++) begin
            for (int i = 0; i < NI; i++) tb_stall[i] = ($urandom_range(0, 4) == 0);
            next_cycle();
        end
        tb_stall = '0;
        reset_n = 1'b0;
        repeat (3) next_cycle();
        reset_n = 1'b1;
        repeat (60) next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fft_mult_sched.md
FFT_MULT_SCHED -- requirements
Module: fft_mult_sched

Interface
REQ-001 Parameter PIPE_LAT, default 3, cycles from rd_en to matching wr_en (memory read plus complex multiply plus butterfly add); legal range 1..8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to run a full 64-point transform; sampled only in IDLE.
REQ-005 stall  input  1  high blocks issue of a new butterfly in the current cycle; does not freeze the write-back delay line.
REQ-006 busy  output  1  high in every state except IDLE.
REQ-007 done  output  1  one-cycle pulse when the transform completes.
REQ-008 stage  output  3  current stage 0..5.
REQ-009 rd_en  output  1  butterfly issue strobe: operand read and multiplier launch.
REQ-010 rd_addr_a / rd_addr_b  output  6 each  upper and lower operand addresses.
REQ-011 tw_addr  output  5  twiddle ROM index for the multiplier's 32-bit packed twiddle word.
REQ-012 wr_en  output  1  result write strobe.
REQ-013 wr_addr_a / wr_addr_b  output  6 each  write-back addresses.

Function
REQ-014 The FSM SHALL have the states IDLE, ISSUE, DRAIN and DONE.
REQ-015 IDLE -> ISSUE when start=1; stage=0, k=0 on entry.
REQ-016 In ISSUE with stall=0: rd_en=1, one butterfly k (0..31) issued, k increments; with stall=1: rd_en=0, k held.
REQ-017 Issue of k=31 -> DRAIN; the drain counter is loaded with PIPE_LAT.
REQ-018 DRAIN SHALL last exactly PIPE_LAT cycles with rd_en=0, then -> ISSUE with stage+1, k=0 if stage<5, else -> DONE.
REQ-019 DONE lasts one cycle with done=1, then -> IDLE.
REQ-020 Address math for span=2^stage: group=k>>stage, pos=k&(span-1), rd_addr_a=group*2*span+pos, rd_addr_b=rd_addr_a+span, tw_addr=pos<<(5-stage), all unsigned and truncated to port width.
REQ-021 rd_addr_a, rd_addr_b and tw_addr SHALL be registered outputs valid in the same cycle as rd_en; they hold their last value while rd_en=0.
REQ-022 A PIPE_LAT-deep delay line of {valid, addr_a, addr_b} SHALL produce wr_en/wr_addr_a/wr_addr_b exactly PIPE_LAT cycles after the matching rd_en, independent of stall.
REQ-023 No read of stage s+1 SHALL occur before the last write of stage s (guaranteed by REQ-018).
REQ-024 start while busy=1 SHALL be ignored; start in the DONE cycle SHALL be ignored.
REQ-025 With no stalls, start accepted at cycle 0 gives ISSUE in cycles 1..32 of stage 0, each stage taking 32+PIPE_LAT cycles, and done in cycle 6*(32+PIPE_LAT)+1.
REQ-026 Each stall cycle SHALL extend total latency by exactly one cycle; exactly 192 rd_en and 192 wr_en pulses per transform.

Reset
REQ-027 reset_n=0 SHALL immediately force state IDLE, stage=0, k=0, drain counter=0, busy=0, done=0, rd_en=0, wr_en=0, all address outputs=0, and clear the delay line, including when reset is asserted mid-transform.
REQ-028 After reset release, no wr_en SHALL appear until a new start is accepted and PIPE_LAT cycles have elapsed.

Verification
REQ-029 PIPE_LAT=3, single start, no stall -> rd_en in cycles 1..32, 36..67, ...; done=1 only in cycle 211; 192 reads and 192 writes.
REQ-030 Stage 0 k=5 -> addr_a=10, addr_b=11, tw=0; stage 3 k=13 -> addr_a=21, addr_b=29, tw=20; stage 5 k=31 -> addr_a=31, addr_b=63, tw=31.
REQ-031 stall=1 for 4 cycles at stage 2 k=7 -> k held at 7, rd_en=0 for those cycles, wr_en pulses continue for already-issued butterflies, done moves to cycle 215.
REQ-032 start pulsed again at cycle 50 and in the DONE cycle -> ignored; no restart; stage and k unaffected.
REQ-033 reset_n dropped at cycle 100 -> same cycle all outputs 0 and busy=0; with no new start, no wr_en follows after release.
REQ-034 PIPE_LAT=1 and PIPE_LAT=8 runs -> wr_en lags rd_en by exactly 1 and 8 cycles; done in cycles 199 and 241.
